// File: rtl/cond_logic_if.sv
// Controller-facing signal bundle for cond_logic; the statistics counters
// are present only when COND_STATS_EN is defined.
interface cond_logic_if #(
    parameter int CNT_W = 32
);
    logic [3:0] ALUFlags;
    logic [3:0] Cond;
    logic       InstrStart;
    logic [1:0] FlagW;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;
`ifdef COND_STATS_EN
    logic [CNT_W-1:0] ExecCnt;
    logic [CNT_W-1:0] SkipCnt;
`endif

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("cond_logic_if: CNT_W must be at least 1");
    end

    modport master (
        output ALUFlags, Cond, InstrStart, FlagW, PCS, NextPC, RegW, MemW,
`ifdef COND_STATS_EN
        input  ExecCnt, SkipCnt,
`endif
        input  PCWrite, RegWrite, MemWrite, CondEx, Flags
    );

    modport slave (
        input  ALUFlags, Cond, InstrStart, FlagW, PCS, NextPC, RegW, MemW,
`ifdef COND_STATS_EN
        output ExecCnt, SkipCnt,
`endif
        output PCWrite, RegWrite, MemWrite, CondEx, Flags
    );
endinterface

// File: rtl/cond_logic.sv
// Conditional-execution and flag-storage unit: holds NZCV, evaluates the
// condition field at Decode, gates write strobes. Optional counters: COND_STATS_EN.
module cond_logic #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    cond_logic_if.slave bus
);
    logic [3:0] flags_reg;
    logic [3:0] flags_next;
    logic       cond_ex_reg;
    logic       check_pass;
    logic       cond_ex;
    logic       write_ok;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_reg;

    always_comb begin
        check_pass = 1'b1;
        case (bus.Cond)
            4'b0000: check_pass = z_f;
            4'b0001: check_pass = ~z_f;
            4'b0010: check_pass = c_f;
            4'b0011: check_pass = ~c_f;
            4'b0100: check_pass = n_f;
            4'b0101: check_pass = ~n_f;
            4'b0110: check_pass = v_f;
            4'b0111: check_pass = ~v_f;
            4'b1000: check_pass = c_f & ~z_f;
            4'b1001: check_pass = ~c_f | z_f;
            4'b1010: check_pass = n_f ~^ v_f;
            4'b1011: check_pass = n_f ^ v_f;
            4'b1100: check_pass = ~z_f & (n_f ~^ v_f);
            4'b1101: check_pass = z_f | (n_f ^ v_f);
            default: check_pass = 1'b1;
        endcase
    end

    // In the Decode cycle the fresh verdict is used directly, so a flag write
    // in that same cycle is gated by the instruction's own condition.
    assign cond_ex  = bus.InstrStart ? check_pass : cond_ex_reg;
    // Keeps gated strobes low while reset is held, even if InstrStart is high.
    assign write_ok = cond_ex & reset_n;

    for (genvar gi = 0; gi < 2; gi++) begin : g_flag_half
        assign flags_next[2*gi +: 2] = (bus.FlagW[gi] & cond_ex) ?
                                       bus.ALUFlags[2*gi +: 2] : flags_reg[2*gi +: 2];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_reg   <= 4'b0000;
            cond_ex_reg <= 1'b0;
        end else begin
            flags_reg <= flags_next;
            if (bus.InstrStart) begin
                cond_ex_reg <= check_pass;
            end
        end
    end

    assign bus.CondEx   = cond_ex;
    assign bus.Flags    = flags_reg;
    assign bus.PCWrite  = (bus.PCS & write_ok) | bus.NextPC;
    assign bus.RegWrite = bus.RegW & write_ok;
    assign bus.MemWrite = bus.MemW & write_ok;

`ifdef COND_STATS_EN
    logic [CNT_W-1:0] exec_cnt_reg;
    logic [CNT_W-1:0] skip_cnt_reg;

    // Saturating counters: stick at all-ones rather than wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_cnt_reg <= '0;
            skip_cnt_reg <= '0;
        end else if (bus.InstrStart) begin
            if (check_pass) begin
                if (exec_cnt_reg != '1) begin
                    exec_cnt_reg <= exec_cnt_reg + 1'b1;
                end
            end else if (skip_cnt_reg != '1) begin
                skip_cnt_reg <= skip_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.ExecCnt = exec_cnt_reg;
    assign bus.SkipCnt = skip_cnt_reg;
`endif

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("cond_logic: CNT_W must be at least 1");
    end
endmodule
